board_controller: RTL and testbench
===================================

Name: board_controller

Overview:
Game-state producer for the 8x8 minesweeper board. It generates the mineMap, flagMap, stepMap and posMap vectors that the board renderer reads every frame. It turns one-cycle player command pulses into cursor moves, flag toggles and steps, places mines pseudo-randomly at game start, and tracks whether the game is lost or won. Tile index = row*8 + col, so row = tile[5:3] and col = tile[2:0], matching the renderer's tile numbering.

Parameters:
NUM_MINES, 10, number of mines placed per game; legal range 1..63.
LFSR_SEED, 16'hACE1, LFSR value loaded at reset; must be non-zero.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
new_game  in  1  pulse: clear the board and start mine placement
move_up  in  1  pulse: cursor row-1
move_down  in  1  pulse: cursor row+1
move_left  in  1  pulse: cursor col-1
move_right  in  1  pulse: cursor col+1
step_req  in  1  pulse: step on the cursor tile
flag_req  in  1  pulse: toggle the flag on the cursor tile
mineMap  out  64  bit t = 1 if tile t holds a mine
flagMap  out  64  bit t = 1 if tile t is flagged
stepMap  out  64  bit t = 1 if tile t is revealed
posMap  out  64  one-hot cursor position
flag_count  out  7  number of set flagMap bits
busy  out  1  high while in PLACE
game_over  out  1  high in LOST
win  out  1  high in WON

Behaviour:
- All outputs are registered. A command sampled on edge N is visible after edge N.
- Reset values: all maps 0 except posMap = 64'h1 (tile 0); flag_count = 0; state = IDLE; busy/game_over/win = 0; LFSR = LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. It advances every cycle in every state, so the board depends on player timing.
- Command priority in one cycle: new_game > step_req > flag_req > move_up > move_down > move_left > move_right. Only the highest-priority command acts; the rest are dropped.
- States:
  - IDLE: moves are accepted. new_game -> PLACE. All other commands are ignored.
  - PLACE: busy = 1. Each cycle the candidate tile is lfsr[5:0].
    - If the candidate is not a mine and is not the cursor tile, set its mineMap bit and increment the internal count.
    - When count reaches NUM_MINES -> PLAY.
    - Every command except reset is ignored in PLACE.
  - PLAY: moves, step and flag are accepted; new_game -> PLACE.
    - Step on a flagged or already-stepped tile: ignored.
    - Step on a mine: stepMap |= mineMap, go to LOST.
    - Step on a safe tile: set its stepMap bit. If the stepped-tile count becomes 64-NUM_MINES, go to WON in that same transition.
    - Flag on a stepped tile: ignored. Otherwise toggle the flag bit and adjust flag_count by +1 or -1.
  - LOST / WON: only new_game (-> PLACE) and reset are honoured. Maps are held.
- new_game from any state except PLACE:
  - clear mineMap, flagMap and stepMap, and zero flag_count and the counters;
  - keep the cursor position (first step is always safe);
  - enter PLACE on the next cycle.
- Cursor at an edge: a move off the board saturates (no change) unless CURSOR_WRAP_EN is defined.
- Reset mid-PLACE or mid-PLAY returns everything to reset values in one cycle.
- Stepped-tile counter is 7 bits; the mine counter is 6 bits. No overflow is possible within the legal NUM_MINES range.

Optional Feature:
CURSOR_WRAP_EN
- Defined: edge moves wrap modulo 8 within the row or column (col 7 + right -> col 0; row 0 + up -> row 7).
- Undefined: edge moves are ignored and the cursor stays put.

Decomposition:
- Shared package holds:
  - state enum {IDLE, PLACE, PLAY, LOST, WON};
  - BOARD_DIM = 8 and TILE_W = 6;
  - LFSR_TAPS and the default seed.
- One sub-module, lfsr16 (clk, reset, seed, out[15:0]), free-running.
- Cursor logic, maps and FSM stay in board_controller.

Test Plan:
1. Reset for 2 cycles -> posMap = 64'h1, all other maps 0, flag_count = 0, busy = game_over = win = 0.
2. new_game with cursor at tile 27, NUM_MINES = 10 -> busy high until popcount(mineMap) = 10 and mineMap[27] = 0, then busy falls and the state is PLAY.
3. Cursor at tile 0: move_left, then move_up -> posMap = 64'h1 unwrapped. With CURSOR_WRAP_EN -> posMap bit 7, then bit 63.
4. flag_req on safe tile 27 -> flagMap[27] = 1, flag_count = 1. Then step_req -> stepMap unchanged. Then flag_req -> flag_count = 0. Then step_req -> stepMap[27] = 1.
5. Move to a tile with its mineMap bit set and step_req -> game_over = 1 and stepMap includes all mineMap bits. Then move and step are ignored; new_game -> busy = 1.
6. Bench reads mineMap and steps every non-mine tile -> win = 1 on the 54th step (NUM_MINES = 10); simultaneous step_req + flag_req on that step still wins.

Source files
------------

// File: rtl/board_controller_pkg.sv
// Shared types and constants for the minesweeper board controller.
// Tile numbering: tile = row*BOARD_DIM + col, row = tile[5:3], col = tile[2:0].
package board_controller_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLACE = 3'd1,
        PLAY  = 3'd2,
        LOST  = 3'd3,
        WON   = 3'd4
    } state_e;

    localparam int BOARD_DIM = 8;
    localparam int TILE_W    = 6;

    // Feedback mask for x^16+x^14+x^13+x^11+1 with a left-shifting register.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/board_controller_if.sv
// Player-command and board-map bundle between the input front end/renderer
// (master) and board_controller (slave).
interface board_controller_if;
    logic        new_game;
    logic        move_up;
    logic        move_down;
    logic        move_left;
    logic        move_right;
    logic        step_req;
    logic        flag_req;
    logic [63:0] mineMap;
    logic [63:0] flagMap;
    logic [63:0] stepMap;
    logic [63:0] posMap;
    logic [6:0]  flag_count;
    logic        busy;
    logic        game_over;
    logic        win;

    modport master (
        output new_game, move_up, move_down, move_left, move_right, step_req, flag_req,
        input  mineMap, flagMap, stepMap, posMap, flag_count, busy, game_over, win
    );

    modport slave (
        input  new_game, move_up, move_down, move_left, move_right, step_req, flag_req,
        output mineMap, flagMap, stepMap, posMap, flag_count, busy, game_over, win
    );
endinterface

// File: rtl/board_controller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the mine-placement random source.
module lfsr16
    import board_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/board_controller.sv
// Minesweeper game-state producer: cursor, mine placement, flag/step maps, win/loss FSM.
// Build option: define CURSOR_WRAP_EN to make edge moves wrap instead of saturate.
module board_controller
    import board_controller_pkg::*;
#(
    parameter int          NUM_MINES = 10,
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               reset,
    board_controller_if.slave  bus
);

    state_e              state_q, state_d;
    logic [63:0]         mine_q, mine_d;
    logic [63:0]         flag_q, flag_d;
    logic [63:0]         step_q, step_d;
    logic [63:0]         pos_q, pos_d;
    logic [TILE_W-1:0]   cursor_q, cursor_d;
    logic [6:0]          flag_cnt_q, flag_cnt_d;
    logic [6:0]          step_cnt_q, step_cnt_d;
    logic [5:0]          mine_cnt_q, mine_cnt_d;
    logic                busy_q, lost_q, won_q;

    logic [15:0]         lfsr;
    logic [TILE_W-1:0]   cand;
    logic                unused_lfsr_hi;
    logic [2:0]          row, col, move_row, move_col;
    logic                start_game;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .out   (lfsr)
    );

    assign cand           = lfsr[TILE_W-1:0];
    assign unused_lfsr_hi = ^lfsr[15:TILE_W];
    assign row            = cursor_q[5:3];
    assign col            = cursor_q[2:0];

    // Highest-priority move only; 3-bit arithmetic gives the modulo-8 wrap.
    always_comb begin
        move_row = row;
        move_col = col;
        if (bus.move_up) begin
`ifdef CURSOR_WRAP_EN
            move_row = row - 3'd1;
`else
            if (row != 3'd0) move_row = row - 3'd1;
`endif
        end else if (bus.move_down) begin
`ifdef CURSOR_WRAP_EN
            move_row = row + 3'd1;
`else
            if (row != 3'd7) move_row = row + 3'd1;
`endif
        end else if (bus.move_left) begin
`ifdef CURSOR_WRAP_EN
            move_col = col - 3'd1;
`else
            if (col != 3'd0) move_col = col - 3'd1;
`endif
        end else if (bus.move_right) begin
`ifdef CURSOR_WRAP_EN
            move_col = col + 3'd1;
`else
            if (col != 3'd7) move_col = col + 3'd1;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        mine_d     = mine_q;
        flag_d     = flag_q;
        step_d     = step_q;
        cursor_d   = cursor_q;
        flag_cnt_d = flag_cnt_q;
        step_cnt_d = step_cnt_q;
        mine_cnt_d = mine_cnt_q;
        start_game = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.new_game) begin
                    start_game = 1'b1;
                end else if (!bus.step_req && !bus.flag_req) begin
                    cursor_d = {move_row, move_col};
                end
            end
            PLACE: begin
                // The cursor tile is kept mine-free so the opening step is always safe.
                if (!mine_q[cand] && (cand != cursor_q)) begin
                    mine_d[cand] = 1'b1;
                    mine_cnt_d   = mine_cnt_q + 6'd1;
                    if (mine_cnt_q + 6'd1 == 6'(NUM_MINES)) state_d = PLAY;
                end
            end
            PLAY: begin
                if (bus.new_game) begin
                    start_game = 1'b1;
                end else if (bus.step_req) begin
                    if (!flag_q[cursor_q] && !step_q[cursor_q]) begin
                        if (mine_q[cursor_q]) begin
                            step_d  = step_q | mine_q;
                            state_d = LOST;
                        end else begin
                            step_d[cursor_q] = 1'b1;
                            step_cnt_d       = step_cnt_q + 7'd1;
                            if (step_cnt_q + 7'd1 == 7'(64 - NUM_MINES)) state_d = WON;
                        end
                    end
                end else if (bus.flag_req) begin
                    if (!step_q[cursor_q]) begin
                        flag_d[cursor_q] = ~flag_q[cursor_q];
                        flag_cnt_d = flag_q[cursor_q] ? flag_cnt_q - 7'd1 : flag_cnt_q + 7'd1;
                    end
                end else begin
                    cursor_d = {move_row, move_col};
                end
            end
            LOST, WON: begin
                if (bus.new_game) start_game = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (start_game) begin
            mine_d     = '0;
            flag_d     = '0;
            step_d     = '0;
            flag_cnt_d = '0;
            step_cnt_d = '0;
            mine_cnt_d = '0;
            state_d    = PLACE;
        end
    end

    for (genvar gi = 0; gi < 64; gi++) begin : g_pos
        assign pos_d[gi] = (cursor_d == TILE_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mine_q     <= '0;
            flag_q     <= '0;
            step_q     <= '0;
            pos_q      <= 64'h1;
            cursor_q   <= '0;
            flag_cnt_q <= '0;
            step_cnt_q <= '0;
            mine_cnt_q <= '0;
            busy_q     <= 1'b0;
            lost_q     <= 1'b0;
            won_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mine_q     <= mine_d;
            flag_q     <= flag_d;
            step_q     <= step_d;
            pos_q      <= pos_d;
            cursor_q   <= cursor_d;
            flag_cnt_q <= flag_cnt_d;
            step_cnt_q <= step_cnt_d;
            mine_cnt_q <= mine_cnt_d;
            busy_q     <= (state_d == PLACE);
            lost_q     <= (state_d == LOST);
            won_q      <= (state_d == WON);
        end
    end

    assign bus.mineMap    = mine_q;
    assign bus.flagMap    = flag_q;
    assign bus.stepMap    = step_q;
    assign bus.posMap     = pos_q;
    assign bus.flag_count = flag_cnt_q;
    assign bus.busy       = busy_q;
    assign bus.game_over  = lost_q;
    assign bus.win        = won_q;

endmodule

// File: tb/tb_board_controller.sv
// Self-checking bench for board_controller: table-driven cursor vectors, directed game
// sequences and randomized play, all compared against a rule-level game model.
module tb_board_controller;

    localparam int          NUM_MINES = 10;
    localparam logic [15:0] SEED      = 16'hACE1;
`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    // Command mask bits
    localparam bit [6:0] C_NG = 7'b0000001, C_ST = 7'b0000010, C_FL = 7'b0000100,
                         C_UP = 7'b0001000, C_DN = 7'b0010000, C_LF = 7'b0100000,
                         C_RT = 7'b1000000;
    localparam int S_IDLE = 0, S_PLACE = 1, S_PLAY = 2, S_LOST = 3, S_WON = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    board_controller_if bus ();

    board_controller #(.NUM_MINES(NUM_MINES), .LFSR_SEED(SEED)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference game model
    bit          m_mine[64];
    bit          m_flag[64];
    bit          m_step[64];
    int          m_pos, m_state, m_fc, m_sc, m_mc;
    logic [15:0] m_lfsr;

    typedef struct {
        bit [6:0] mask;
        int       exp_nowrap;
        int       exp_wrap;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(bit a[64]);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic new_board();
        for (int i = 0; i < 64; i++) begin
            m_mine[i] = 0; m_flag[i] = 0; m_step[i] = 0;
        end
        m_fc = 0; m_sc = 0; m_mc = 0;
        m_state = S_PLACE;
    endtask

    task automatic model_move(bit up, bit dn, bit lf, bit rt);
        int r, c;
        r = m_pos / 8;
        c = m_pos % 8;
        if (up)      begin if (r > 0) r = r - 1; else if (WRAP) r = 7; end
        else if (dn) begin if (r < 7) r = r + 1; else if (WRAP) r = 0; end
        else if (lf) begin if (c > 0) c = c - 1; else if (WRAP) c = 7; end
        else if (rt) begin if (c < 7) c = c + 1; else if (WRAP) c = 0; end
        m_pos = r * 8 + c;
    endtask

    task automatic model_step();
        bit ng, st, fl;
        int cand;
        logic [15:0] nl;
        ng = bus.new_game; st = bus.step_req; fl = bus.flag_req;
        nl = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (reset) begin
            new_board();
            m_state = S_IDLE;
            m_pos   = 0;
            m_lfsr  = SEED;
            return;
        end
        case (m_state)
            S_IDLE: begin
                if (ng) new_board();
                else if (!st && !fl) model_move(bus.move_up, bus.move_down, bus.move_left, bus.move_right);
            end
            S_PLACE: begin
                cand = int'(m_lfsr[5:0]);
                if (!m_mine[cand] && cand != m_pos) begin
                    m_mine[cand] = 1;
                    m_mc++;
                    if (m_mc == NUM_MINES) m_state = S_PLAY;
                end
            end
            S_PLAY: begin
                if (ng) new_board();
                else if (st) begin
                    if (!m_flag[m_pos] && !m_step[m_pos]) begin
                        if (m_mine[m_pos]) begin
                            for (int i = 0; i < 64; i++) if (m_mine[i]) m_step[i] = 1;
                            m_state = S_LOST;
                        end else begin
                            m_step[m_pos] = 1;
                            m_sc++;
                            if (m_sc == 64 - NUM_MINES) m_state = S_WON;
                        end
                    end
                end else if (fl) begin
                    if (!m_step[m_pos]) begin
                        m_fc += m_flag[m_pos] ? -1 : 1;
                        m_flag[m_pos] = !m_flag[m_pos];
                    end
                end else model_move(bus.move_up, bus.move_down, bus.move_left, bus.move_right);
            end
            default: begin
                if (ng) new_board();
            end
        endcase
        m_lfsr = nl;
    endtask

    task automatic compare_all();
        chk("mineMap", bus.mineMap, pack(m_mine));
        chk("flagMap", bus.flagMap, pack(m_flag));
        chk("stepMap", bus.stepMap, pack(m_step));
        chk("posMap", bus.posMap, 64'h1 << m_pos);
        chk("flag_count", 64'(bus.flag_count), 64'(m_fc));
        chk("busy", 64'(bus.busy), 64'(m_state == S_PLACE));
        chk("game_over", 64'(bus.game_over), 64'(m_state == S_LOST));
        chk("win", 64'(bus.win), 64'(m_state == S_WON));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic apply(bit [6:0] mask);
        bus.new_game   = mask[0];
        bus.step_req   = mask[1];
        bus.flag_req   = mask[2];
        bus.move_up    = mask[3];
        bus.move_down  = mask[4];
        bus.move_left  = mask[5];
        bus.move_right = mask[6];
        tick();
        bus.new_game = 0; bus.step_req = 0; bus.flag_req = 0;
        bus.move_up = 0; bus.move_down = 0; bus.move_left = 0; bus.move_right = 0;
    endtask

    task automatic goto(int t);
        for (int k = 0; k < 32 && m_pos != t; k++) begin
            if (m_pos / 8 < t / 8)      apply(C_DN);
            else if (m_pos / 8 > t / 8) apply(C_UP);
            else if (m_pos % 8 < t % 8) apply(C_RT);
            else                        apply(C_LF);
        end
    endtask

    task automatic wait_place(string name);
        for (int k = 0; k < 4000 && bus.busy; k++) apply(0);
        chk(name, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int exp, mine_t, last_t, nsafe;
        bit [6:0] m;

        tbl[0] = '{C_LF, 0, 7};
        tbl[1] = '{C_UP, 0, 63};
        tbl[2] = '{C_RT, 1, 56};
        tbl[3] = '{C_DN, 9, 0};
        tbl[4] = '{C_DN, 17, 8};
        tbl[5] = '{C_RT, 18, 9};
        tbl[6] = '{C_UP, 10, 1};
        tbl[7] = '{C_ST | C_DN, 10, 1};
        tbl[8] = '{C_UP | C_RT, 2, 57};

        m_lfsr = SEED;
        new_board();
        m_state = S_IDLE;
        m_pos = 0;

        // Reset for two cycles
        reset = 1;
        apply(0);
        apply(0);
        reset = 0;
        chk("reset_posMap", bus.posMap, 64'h1);
        chk("reset_maps", bus.mineMap | bus.flagMap | bus.stepMap, 64'h0);
        chk("reset_flags", {bus.flag_count, bus.busy, bus.game_over, bus.win}, 64'h0);
        $display("reset done: posMap=%h", bus.posMap);

        // Cursor vectors from tile 0 in IDLE
        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].mask);
            exp = WRAP ? tbl[i].exp_wrap : tbl[i].exp_nowrap;
            chk("cursor_vec", bus.posMap, 64'h1 << exp);
            $display("vec %0d: cmd=%b posMap=%h expected tile %0d", i, tbl[i].mask, bus.posMap, exp);
        end

        // Start a game with the cursor on tile 27
        goto(27);
        apply(C_NG);
        chk("place_busy", 64'(bus.busy), 64'd1);
        wait_place("place_timeout");
        chk("mine_popcount", 64'($countones(bus.mineMap)), 64'(NUM_MINES));
        chk("cursor_safe", 64'(bus.mineMap[27]), 64'd0);
        $display("game started: mineMap=%h", bus.mineMap);

        // Flag / step interplay on tile 27
        apply(C_FL);
        chk("flag_set", 64'(bus.flagMap[27]), 64'd1);
        chk("flag_count_1", 64'(bus.flag_count), 64'd1);
        apply(C_ST);
        chk("step_on_flag", bus.stepMap, 64'h0);
        apply(C_FL);
        chk("flag_count_0", 64'(bus.flag_count), 64'd0);
        apply(C_ST);
        chk("step_safe", 64'(bus.stepMap[27]), 64'd1);
        $display("flag/step on 27: stepMap=%h flagMap=%h", bus.stepMap, bus.flagMap);

        // Step on a mine
        mine_t = 0;
        for (int i = 63; i >= 0; i--) if (m_mine[i]) mine_t = i;
        goto(mine_t);
        apply(C_ST);
        chk("lost", 64'(bus.game_over), 64'd1);
        chk("lost_reveal", bus.stepMap & bus.mineMap, bus.mineMap);
        apply(C_LF);
        apply(C_ST);
        apply(C_NG);
        chk("restart_busy", 64'(bus.busy), 64'd1);
        $display("lost on tile %0d, restarted", mine_t);
        wait_place("place_timeout2");

        // Reveal every safe tile; the final step carries a simultaneous flag request
        last_t = 0;
        nsafe = 0;
        for (int i = 0; i < 64; i++) if (!m_mine[i]) begin last_t = i; nsafe++; end
        chk("safe_count", 64'(nsafe), 64'(64 - NUM_MINES));
        for (int i = 0; i < 64; i++) begin
            if (!m_mine[i] && i != last_t) begin
                goto(i);
                apply(C_ST);
            end
        end
        chk("no_early_win", 64'(bus.win), 64'd0);
        goto(last_t);
        apply(C_ST | C_FL);
        chk("win", 64'(bus.win), 64'd1);
        chk("win_flags", bus.flagMap, 64'h0);
        $display("won: stepMap=%h", bus.stepMap);

        // Randomized play over several games
        apply(C_NG);
        wait_place("place_timeout3");
        for (int k = 0; k < 1500; k++) begin
            m = '0;
            if ($urandom_range(0, 99) < 2)  m |= C_NG;
            if ($urandom_range(0, 99) < 15) m |= C_ST;
            if ($urandom_range(0, 99) < 15) m |= C_FL;
            if ($urandom_range(0, 99) < 30) m |= C_UP;
            if ($urandom_range(0, 99) < 30) m |= C_DN;
            if ($urandom_range(0, 99) < 30) m |= C_LF;
            if ($urandom_range(0, 99) < 30) m |= C_RT;
            if (k % 300 == 299) reset = 1;
            apply(m);
            reset = 0;
        end
        $display("random phase done: state=%0d flag_count=%0d", m_state, m_fc);

        // Reset in the middle of mine placement
        if (m_state == S_PLACE) wait_place("place_timeout4");
        apply(C_NG);
        apply(0);
        reset = 1;
        apply(0);
        reset = 0;
        chk("midplace_pos", bus.posMap, 64'h1);
        chk("midplace_maps", bus.mineMap | bus.flagMap | bus.stepMap, 64'h0);
        chk("midplace_busy", 64'(bus.busy), 64'd0);
        $display("reset mid-PLACE: busy=%0d", bus.busy);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
